// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_RADDR = 5;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_UDIV = 2'b01,
        OP_SDIV = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-divide step: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning iterator.
module muldiv_divstep #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic             dividendBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic             quotBit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Partial remainder is always below the divisor, so the shifted value fits in WIDTH+1
    // bits and the top bit of the difference is a clean borrow flag.
    always_comb begin
        shifted = {remIn, dividendBit};
        diff    = shifted - {1'b0, divisor};
        quotBit = ~diff[WIDTH];
        remOut  = quotBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 multiply (low half) / unsigned divide unit; optional signed divide under MULDIV_SDIV_EN.
// Latency: accept edge N, WIDTH iteration edges, result/Done at edge N+WIDTH+1.
// Backpressure: Start is taken only in IDLE or DONE; Start while Busy is ignored.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RADDR = DEF_RADDR
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [RADDR-1:0] RdIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [RADDR-1:0] RdOut
);

    localparam int CW = $clog2(WIDTH);

    state_t state;
    state_t stateNext;

    op_t              opIn;
    op_t              opReg;
    logic             accept;
    logic             divIn;
    logic             isDiv;
    logic [CW-1:0]    count;
    logic             finalPhase;
    logic             divZero;
    logic [2*WIDTH-1:0] accReg;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] mcandReg;
    logic [WIDTH-1:0] opbReg;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] remOut;
    logic             quotBit;
    logic [WIDTH-1:0] finalResult;
    logic [WIDTH-1:0] resultReg;
    logic [RADDR-1:0] rdReg;
`ifdef MULDIV_SDIV_EN
    logic             signedIn;
    logic             negQuot;
`endif

    assign opIn   = op_t'(Op);
    assign accept = Start && ((state == S_IDLE) || (state == S_DONE));
    assign Busy   = (state == S_RUN);
    assign Done   = (state == S_DONE);
    assign Result = resultReg;
    assign RdOut  = rdReg;

`ifdef MULDIV_SDIV_EN
    // Signed divide reduces to unsigned on magnitudes; the sign is restored on the final edge.
    always_comb begin
        signedIn = (opIn == OP_SDIV);
        divIn    = (opIn == OP_UDIV) || signedIn;
        isDiv    = (opReg == OP_UDIV) || (opReg == OP_SDIV);
        absA     = (signedIn && OpA[WIDTH-1]) ? -OpA : OpA;
        absB     = (signedIn && OpB[WIDTH-1]) ? -OpB : OpB;
    end
`else
    // Without signed support, SDIV falls through to the reserved (zero-result) path.
    always_comb begin
        divIn = (opIn == OP_UDIV);
        isDiv = (opReg == OP_UDIV);
        absA  = OpA;
        absB  = OpB;
    end
`endif

    muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
        .remIn       (accReg[2*WIDTH-1:WIDTH]),
        .dividendBit (accReg[WIDTH-1]),
        .divisor     (opbReg),
        .remOut      (remOut),
        .quotBit     (quotBit)
    );

    // One iteration: divide shifts {remainder, dividend/quotient}; multiply adds the shifted multiplicand.
    always_comb begin
        accNext = accReg;
        if (isDiv) begin
            accNext = {remOut, accReg[WIDTH-2:0], quotBit};
        end else if (opbReg[0]) begin
            accNext = accReg + mcandReg;
        end
    end

    // Final result selection, including divide-by-zero and sign fix-up.
    always_comb begin
        finalResult = '0;
        case (opReg)
            OP_MUL:  finalResult = accReg[WIDTH-1:0];
            OP_UDIV: finalResult = divZero ? '0 : accReg[WIDTH-1:0];
`ifdef MULDIV_SDIV_EN
            OP_SDIV: finalResult = divZero ? '0 :
                                   (negQuot ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0]);
`endif
            default: finalResult = '0;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: RUN ends on the fix-up edge that follows the last iteration.
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (Start) stateNext = S_RUN;
            S_RUN:   if (finalPhase) stateNext = S_DONE;
            S_DONE:  stateNext = Start ? S_RUN : S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Operand capture at accept, iteration while running, result write on the fix-up edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            opReg      <= OP_MUL;
            rdReg      <= '0;
            count      <= '0;
            finalPhase <= 1'b0;
            divZero    <= 1'b0;
            accReg     <= '0;
            mcandReg   <= '0;
            opbReg     <= '0;
            resultReg  <= '0;
`ifdef MULDIV_SDIV_EN
            negQuot    <= 1'b0;
`endif
        end else if (accept) begin
            opReg      <= opIn;
            rdReg      <= RdIn;
            count      <= CW'(WIDTH - 1);
            finalPhase <= 1'b0;
            divZero    <= (OpB == '0);
            accReg     <= divIn ? {{WIDTH{1'b0}}, absA} : '0;
            mcandReg   <= {{WIDTH{1'b0}}, OpA};
            opbReg     <= divIn ? absB : OpB;
`ifdef MULDIV_SDIV_EN
            negQuot    <= signedIn && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
`endif
        end else if (state == S_RUN) begin
            if (!finalPhase) begin
                accReg   <= accNext;
                mcandReg <= mcandReg << 1;
                opbReg   <= isDiv ? opbReg : (opbReg >> 1);
                if (count == '0) begin
                    finalPhase <= 1'b1;
                end else begin
                    count <= count - CW'(1);
                end
            end else begin
                resultReg  <= finalResult;
                finalPhase <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit against an arithmetic reference model.
// Latency: expects Done exactly 65 edges after each accept.
// Backpressure: checks that Start during RUN is ignored and back-to-back Start works from DONE.
module tb_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [63:0] OpA = '0;
    logic [63:0] OpB = '0;
    logic [4:0]  RdIn = '0;
    logic        Busy;
    logic        Done;
    logic [63:0] Result;
    logic [4:0]  RdOut;

    int errors = 0;
    int checks = 0;

    localparam int LAT = 65;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    always #5 Clk = ~Clk;

    muldiv_unit dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Op      (Op),
        .OpA     (OpA),
        .OpB     (OpB),
        .RdIn    (RdIn),
        .Busy    (Busy),
        .Done    (Done),
        .Result  (Result),
        .RdOut   (RdOut)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural meaning of each opcode.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: return a * b;
            2'b01: return (b == 0) ? 64'd0 : a / b;
`ifdef MULDIV_SDIV_EN
            2'b10: begin
                if (b == 0) return 64'd0;
                if (a == MIN64 && b == '1) return MIN64;
                return sa / sb;
            end
`endif
            default: return 64'd0;
        endcase
    endfunction

    task automatic doOp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] expRes, input string tag,
                        input int pokeAt);
        int edges;
        logic [63:0] held;
        @(negedge Clk);
        Start = 1'b1; Op = op; OpA = a; OpB = b; RdIn = rd;
        @(negedge Clk);
        Start = 1'b0;
        edges = 0;
        check({tag, "_busy"}, 64'(Busy), 64'd1);
        check({tag, "_rdcap"}, 64'(RdOut), 64'(rd));
        held = Result;
        Op = 2'($urandom); OpA = {$urandom, $urandom}; OpB = {$urandom, $urandom};
        RdIn = 5'($urandom);
        while (!Done && edges < 200) begin
            Start = (edges == pokeAt);
            @(negedge Clk);
            edges++;
            if (pokeAt >= 0 && edges == pokeAt + 1) begin
                check({tag, "_pokeBusy"}, 64'(Busy), 64'd1);
                check({tag, "_pokeHeld"}, Result, held);
            end
        end
        Start = 1'b0;
        check({tag, "_lat"}, 64'(edges), 64'(LAT));
        check({tag, "_res"}, Result, expRes);
        check({tag, "_rd"}, 64'(RdOut), 64'(rd));
        check({tag, "_busyLow"}, 64'(Busy), 64'd0);
        @(negedge Clk);
        check({tag, "_donePulse"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int edges;
        logic sawDone;
        logic [1:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0] rd;

        // Reset state
        #12;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_result", Result, 64'd0);
        check("rst_rdout", 64'(RdOut), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed multiply, divide, divide-by-zero, Start poke during RUN
        doOp(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, "mulMax", -1);
        doOp(2'b01, 64'd100, 64'd7, 5'd12, 64'd14, "udiv100_7", 10);
        doOp(2'b01, 64'd5, 64'd0, 5'd1, 64'd0, "udivZero", -1);

        // Back-to-back: Start held high through DONE
        @(negedge Clk);
        Start = 1'b1; Op = 2'b00; OpA = 64'd6; OpB = 64'd7; RdIn = 5'd3;
        @(negedge Clk);
        edges = 0;
        Op = 2'b01; OpA = 64'd42; OpB = 64'd6; RdIn = 5'd4;
        while (!Done && edges < 200) begin
            @(negedge Clk);
            edges++;
        end
        check("b2b1_lat", 64'(edges), 64'(LAT));
        check("b2b1_res", Result, 64'd42);
        check("b2b1_rd", 64'(RdOut), 64'd3);
        @(negedge Clk);
        Start = 1'b0;
        edges = 0;
        check("b2b_doneDrop", 64'(Done), 64'd0);
        check("b2b_busyRise", 64'(Busy), 64'd1);
        while (!Done && edges < 200) begin
            @(negedge Clk);
            edges++;
        end
        check("b2b2_lat", 64'(edges), 64'(LAT));
        check("b2b2_res", Result, 64'd7);
        check("b2b2_rd", 64'(RdOut), 64'd4);
        @(negedge Clk);
        check("b2b2_donePulse", 64'(Done), 64'd0);

        // Reset during RUN aborts the operation
        @(negedge Clk);
        Start = 1'b1; Op = 2'b01; OpA = 64'd1000; OpB = 64'd3; RdIn = 5'd9;
        @(negedge Clk);
        Start = 1'b0;
        repeat (20) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_result", Result, 64'd0);
        check("abort_rdout", 64'(RdOut), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        sawDone = 1'b0;
        repeat (80) begin
            @(negedge Clk);
            if (Done || Busy) sawDone = 1'b1;
        end
        check("abort_quiet", 64'(sawDone), 64'd0);
        doOp(2'b00, 64'd3, 64'd5, 5'd2, 64'd15, "mul3_5", -1);

        // Signed divide (or reserved behaviour when the feature is built out)
`ifdef MULDIV_SDIV_EN
        doOp(2'b10, -64'sd7, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, "sdivNeg7_2", -1);
        doOp(2'b10, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, MIN64, "sdivOvf", -1);
        doOp(2'b10, 64'd9, 64'd0, 5'd8, 64'd0, "sdivZero", -1);
`else
        doOp(2'b10, -64'sd7, 64'd2, 5'd5, 64'd0, "sdivOff", -1);
`endif
        doOp(2'b11, 64'd9, 64'd9, 5'd10, 64'd0, "rsvd", -1);

        // Randomized operations against the reference model
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 100));
                2:       b = {$urandom, $urandom};
                default: b = 64'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) a = 64'($urandom_range(0, 100000));
            rd = 5'($urandom);
            doOp(op, a, b, rd, model(op, a, b), "rand", -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
